// File: rtl/bch_enc_ctrl.sv
// bch_enc_ctrl: byte-framed systematic BCH(63,51)-shortened encoder, 12 parity bits appended
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   data_in  in   [7:0] message byte stream, first byte of a slot is the message MSB byte
//   data_enc out  [7:0] registered codeword byte stream {msg, parity, zero pad}, one slot late
module bch_enc_ctrl #(
    parameter int MSG_BITS = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    output logic [7:0] data_enc
);
    localparam int PAR_BITS    = 12;
    localparam int IN_BYTES    = MSG_BITS / 8;
    localparam int FRAME_BYTES = (MSG_BITS + PAR_BITS + 7) / 8;
    localparam int CW_BITS     = FRAME_BYTES * 8;
    localparam int PAD_BITS    = CW_BITS - MSG_BITS - PAR_BITS;
    localparam int CNT_W       = $clog2(FRAME_BYTES);
    localparam logic [PAR_BITS-1:0] G_LOW = 12'h539;

    logic [CNT_W-1:0]    cnt;
    logic [MSG_BITS-1:0] msg;
    logic [PAR_BITS-1:0] lfsr;
    logic [CW_BITS-1:0]  sh;
    logic [CW_BITS-1:0]  cw;
    logic                last;
    logic                cap;

    // Eight MSB-first division steps of the parity remainder by g(x).
    function automatic logic [PAR_BITS-1:0] lfsr_step(input logic [PAR_BITS-1:0] p, input logic [7:0] b);
        logic [PAR_BITS-1:0] r;
        logic                fb;
        r = p;
        for (int i = 7; i >= 0; i--) begin
            fb = r[PAR_BITS-1] ^ b[i];
            r  = {r[PAR_BITS-2:0], 1'b0} ^ (fb ? G_LOW : '0);
        end
        return r;
    endfunction

    always_comb begin
        last = cnt == CNT_W'(FRAME_BYTES - 1);
        cap  = cnt < CNT_W'(IN_BYTES);
        cw   = {msg, lfsr, {PAD_BITS{1'b0}}};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            msg      <= '0;
            lfsr     <= '0;
            sh       <= '0;
            data_enc <= 8'h00;
        end else begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
                // Hand the finished frame to the output shifter and start the next slot clean.
                data_enc <= cw[CW_BITS-1 -: 8];
                sh       <= cw << 8;
                msg      <= '0;
                lfsr     <= '0;
            end else begin
                data_enc <= sh[CW_BITS-1 -: 8];
                sh       <= sh << 8;
                if (cap) begin
                    msg  <= (msg << 8) | MSG_BITS'(data_in);
                    lfsr <= lfsr_step(lfsr, data_in);
                end
            end
        end
    end
endmodule

// File: tb/tb_bch_enc_ctrl.sv
// tb_bch_enc_ctrl: table-driven checks of bch_enc_ctrl with default MSG_BITS=24
module tb_bch_enc_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_enc;
    int         errors = 0;
    int         checks = 0;

    bch_enc_ctrl #(.MSG_BITS(24)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .data_enc (data_enc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] msg;
        logic [7:0]  x3;
        logic [7:0]  x4;
        logic [39:0] exp;
    } vec_t;

    vec_t        tbl[7];
    logic [39:0] seen[7];
    logic [39:0] tmp;

    // Reference: long division of msg*x^12 by 0x1539.
    function automatic logic [39:0] cw_model(input logic [23:0] m);
        logic [35:0] v;
        v = {m, 12'h000};
        for (int i = 35; i >= 12; i--)
            if (v[i]) v = v ^ (36'h1539 << (i - 12));
        return {m, v[11:0], 4'h0};
    endfunction

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One slot: feed m (plus x3/x4 in the ignored cycles) while checking the previous frame comes out.
    task automatic run_slot(input logic [23:0] m, input logic [7:0] x3, input logic [7:0] x4,
                            input logic [39:0] prev, input string name, output logic [39:0] got);
        logic [7:0] b;
        got = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("%s byte%0d", name, k), 40'(data_enc), 40'(prev[39-8*k -: 8]));
            got = {got[31:0], data_enc};
            b = (m >> (16 - 8 * k));
            data_in = k < 3 ? b : (k == 3 ? x3 : x4);
        end
    endtask

    initial begin
        tbl[0] = '{24'h000000, 8'h00, 8'h00, 40'h0000000000};
        tbl[1] = '{24'h000001, 8'h00, 8'h00, 40'h0000015390};
        tbl[2] = '{24'h000002, 8'h00, 8'h00, 40'h000002A720};
        tbl[3] = '{24'hABCDEF, 8'h00, 8'h00, cw_model(24'hABCDEF)};
        tbl[4] = '{24'h000001, 8'hFF, 8'hA5, 40'h0000015390};
        tbl[5] = '{24'h000000, 8'h5A, 8'hC3, 40'h0000000000};
        tbl[6] = '{24'h123456, 8'h00, 8'h00, cw_model(24'h123456)};

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset hold %0d", i), 40'(data_enc), 40'h0);
        end
        @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 7; i++)
            run_slot(tbl[i].msg, tbl[i].x3, tbl[i].x4, i == 0 ? 40'h0 : tbl[i-1].exp,
                     $sformatf("vec%0d", i), seen[i]);
        check("linearity cw1^cw2", seen[2] ^ seen[3], 40'h000003F4B0);

        // Reset mid-slot: in-flight 0x123456 frame and partial new frame must vanish.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("pre-reset byte%0d", k), 40'(data_enc), 40'(tbl[6].exp[39-8*k -: 8]));
            data_in = k == 1 ? 8'h00 : 8'h77;
        end
        @(negedge clk);
        check("pre-reset byte2", 40'(data_enc), 40'(tbl[6].exp[23:16]));
        reset = 1'b0;
        #1 check("async reset clears", 40'(data_enc), 40'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        run_slot(24'h000002, 8'h00, 8'h00, 40'h0, "post-reset flushed", tmp);
        run_slot(24'h000000, 8'h00, 8'h00, 40'h000002A720, "post-reset frame", tmp);
        run_slot(24'h000000, 8'h00, 8'h00, 40'h0, "zero frame", tmp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
